// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg
//   Shared definitions for the MAC sequencer slice: default operand and
//   partial-sum widths, and the sequencer FSM state encoding.
// ---------------------------------------------------------------------------
package mac_pkg;

  localparam int BW_DEF      = 4;   // activation / weight width
  localparam int PSUM_BW_DEF = 16;  // partial-sum width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage : mac_pkg

// File: rtl/mac_seq_fifo.sv
// ---------------------------------------------------------------------------
// mac_seq_fifo
//   Synchronous DEPTH-entry FIFO holding packed (activation, weight) pairs.
//   Pointers carry one extra wrap bit so full and empty are told apart
//   without a separate occupancy counter. The read port is combinational
//   (first-word fall-through), so the head entry can be registered by the
//   consumer in the same cycle it is popped. A pushed entry is only visible
//   after the clock edge that writes it; there is no same-cycle bypass.
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-high reset (empties the FIFO)
//   push   in   write wdata (ignored when full)
//   wdata  in   W-bit entry
//   pop    in   advance read pointer (ignored when empty)
//   rdata  out  head entry (undefined content when empty)
//   full   out  DEPTH entries held
//   empty  out  no entries held
// ---------------------------------------------------------------------------
module mac_seq_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately left out of reset; the pointers alone
  // define which entries are valid, and a resettable array costs a reset
  // net on every bit for no functional gain.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule : mac_seq_fifo

// File: rtl/mac_seq.sv
// ---------------------------------------------------------------------------
// mac_seq
//   Upstream sequencer for mac_wrapper. (activation, weight) pairs are
//   buffered in a small FIFO; one pair is issued per MAC pass and the
//   returned partial sum is fed back as the next c operand. After len pairs
//   the final partial sum is offered on a valid/ready result port.
//   The block never adds: acc is exactly the value returned on mac_out, so
//   any two's-complement wrap comes from mac_wrapper.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   in_valid   in   pair on in_a/in_b valid
//   in_ready   out  FIFO can accept (= !full)
//   in_a       in   activation, unsigned, bw bits
//   in_b       in   weight, two's complement, bw bits
//   start      in   begin a dot product of length len (sampled in IDLE only)
//   len        in   number of pairs to accumulate
//   busy       out  state != IDLE
//   mac_a      out  to mac_wrapper.a
//   mac_b      out  to mac_wrapper.b
//   mac_c      out  to mac_wrapper.c (running accumulator)
//   mac_out    in   from mac_wrapper.out
//   res_valid  out  final partial sum available
//   res_ready  in   consumer accepts result
//   res_data   out  final partial sum
// ---------------------------------------------------------------------------
module mac_seq
  import mac_pkg::*;
#(
  parameter int bw      = BW_DEF,
  parameter int psum_bw = PSUM_BW_DEF,
  parameter int DEPTH   = 4,
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [bw-1:0]      in_a,
  input  logic [bw-1:0]      in_b,
  input  logic               start,
  input  logic [LEN_W-1:0]   len,
  output logic               busy,
  output logic [bw-1:0]      mac_a,
  output logic [bw-1:0]      mac_b,
  output logic [psum_bw-1:0] mac_c,
  input  logic [psum_bw-1:0] mac_out,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [psum_bw-1:0] res_data
);

  localparam int WCNT_W = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

  state_t              state;
  state_t              state_nxt;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [2*bw-1:0]     fifo_rdata;
  logic [LEN_W-1:0]    rem;
  logic [WCNT_W-1:0]   wcnt;
  logic [psum_bw-1:0]  acc;
  logic                last_wait;

  // ------------------------------------------------------------------------
  // Input FIFO: accepts pushes in every state; pops only from ISSUE.
  // ------------------------------------------------------------------------
  mac_seq_fifo #(
    .W     (2 * bw),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid),
    .wdata ({in_a, in_b}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready = !fifo_full;

  // Final WAIT cycle: mac_out is valid for the operands issued MAC_LAT ago.
  assign last_wait = (wcnt == WCNT_W'(1));

  // ------------------------------------------------------------------------
  // FSM state register
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // ------------------------------------------------------------------------
  // FSM next state and pop strobe
  // ------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = (len == '0) ? ST_DONE : ST_ISSUE;
      end
      ST_ISSUE: begin
        // An empty FIFO simply stalls here with mac_* held.
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (last_wait) state_nxt = (rem == LEN_W'(1)) ? ST_DONE : ST_ISSUE;
      end
      ST_DONE: begin
        // start in the handshake cycle is ignored: IDLE only sees it later.
        if (res_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------------
  // Datapath: operand registers, counters, accumulator
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mac_a <= '0;
      mac_b <= '0;
      rem   <= '0;
      wcnt  <= '0;
      acc   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            rem <= len;
            acc <= '0;
          end
        end
        ST_ISSUE: begin
          if (pop) begin
            mac_a <= fifo_rdata[2*bw-1:bw];
            mac_b <= fifo_rdata[bw-1:0];
            wcnt  <= WCNT_W'(MAC_LAT);
          end
        end
        ST_WAIT: begin
          if (last_wait) begin
            acc <= mac_out;
            rem <= rem - 1'b1;
          end else begin
            wcnt <= wcnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // acc only changes at the end of the last WAIT cycle or on start, so
  // driving mac_c straight from it keeps c stable for the whole MAC pass.
  assign mac_c     = acc;
  assign res_data  = acc;
  assign busy      = (state != ST_IDLE);
  assign res_valid = (state == ST_DONE);

endmodule : mac_seq

// File: tb/tb_mac_seq.sv
// ---------------------------------------------------------------------------
// tb_mac_seq
//   Self-checking bench for mac_seq. A behavioural stand-in for mac_wrapper
//   (out = c + a*b, with a unsigned and b signed) closes the loop; with
//   MAC_LAT = 1 its output is valid within the cycle after the sequencer
//   registers new operands. Expected results come from a queue of accepted
//   pairs and plain integer dot products.
// ---------------------------------------------------------------------------
module tb_mac_seq;

  localparam int BW      = 4;
  localparam int PSUM_BW = 16;
  localparam int DEPTH   = 4;
  localparam int LEN_W   = 8;
  localparam int MAC_LAT = 1;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [BW-1:0]      in_a;
  logic [BW-1:0]      in_b;
  logic               start;
  logic [LEN_W-1:0]   len;
  logic               busy;
  logic [BW-1:0]      mac_a;
  logic [BW-1:0]      mac_b;
  logic [PSUM_BW-1:0] mac_c;
  logic [PSUM_BW-1:0] mac_out;
  logic               res_valid;
  logic               res_ready;
  logic [PSUM_BW-1:0] res_data;

  always #5 clk = ~clk;

  mac_seq #(
    .bw      (BW),
    .psum_bw (PSUM_BW),
    .DEPTH   (DEPTH),
    .LEN_W   (LEN_W),
    .MAC_LAT (MAC_LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_c     (mac_c),
    .mac_out   (mac_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data)
  );

  // mac_wrapper stand-in: unsigned a times signed b, plus c, wrapping.
  logic [PSUM_BW-1:0] ext_a;
  logic [PSUM_BW-1:0] ext_b;
  assign ext_a   = PSUM_BW'(mac_a);
  assign ext_b   = {{(PSUM_BW-BW){mac_b[BW-1]}}, mac_b};
  assign mac_out = PSUM_BW'(mac_c + ext_a * ext_b);

  // ------------------------------------------------------------------------
  // Bookkeeping
  // ------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;      // cycles since the last start was driven
  int push_mode = 0;     // 0: manual, 1: random pairs, 2: stream (15,7)
  int push_budget = 0;   // remaining stream pushes in mode 2
  logic [2*BW-1:0] model_q[$];  // accepted pairs, oldest first

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: optionally generate a pair, log an accepted push, advance.
  task automatic tick();
    if (push_mode == 1) begin
      in_valid = 1'($urandom_range(0, 1));
      in_a     = BW'($urandom);
      in_b     = BW'($urandom);
    end else if (push_mode == 2) begin
      in_valid = (push_budget > 0);
      in_a     = BW'(15);
      in_b     = BW'(7);
    end
    if (in_valid && in_ready) begin
      model_q.push_back({in_a, in_b});
      if (push_mode == 2) push_budget--;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_pair(input logic [BW-1:0] a, input logic [BW-1:0] b);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    tick();
    in_valid = 1'b0;
  endtask

  // Reference: wrapped dot product of the n oldest accepted pairs.
  function automatic logic [PSUM_BW-1:0] ref_dot(input int n);
    int s = 0;
    for (int i = 0; i < n && i < model_q.size(); i++) begin
      int a = int'(model_q[i][2*BW-1:BW]);
      int b = int'(model_q[i][BW-1:0]);
      if (b >= (1 << (BW - 1))) b -= (1 << BW);
      s += a * b;
    end
    return PSUM_BW'(s);
  endfunction

  task automatic start_dot(input int n);
    start = 1'b1;
    len   = LEN_W'(n);
    tick();
    start = 1'b0;
    cyc   = 1;
  endtask

  // Wait (bounded) for the result, check latency/data, then handshake.
  task automatic wait_result(input string tag, input int n, input int lat,
                             input bit rnd_ready,
                             output logic [PSUM_BW-1:0] got);
    logic [PSUM_BW-1:0] exp;
    int guard = 0;
    while (!res_valid && guard < 2000) begin
      tick();
      guard++;
    end
    check({tag, "_valid"}, 32'(res_valid), 32'd1);
    if (lat >= 0) check({tag, "_latency"}, 32'(cyc), 32'(lat));
    exp = ref_dot(n);
    got = res_data;
    check({tag, "_data"}, 32'(res_data), 32'(exp));
    for (int i = 0; i < n && model_q.size() > 0; i++) void'(model_q.pop_front());
    if (rnd_ready) begin
      int k = $urandom_range(0, 3);
      repeat (k) tick();
      check({tag, "_hold"}, 32'(res_data), 32'(exp));
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, "_drop"}, 32'(res_valid), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_mac_a"},     32'(mac_a),     32'd0);
    check({tag, "_mac_b"},     32'(mac_b),     32'd0);
    check({tag, "_mac_c"},     32'(mac_c),     32'd0);
    check({tag, "_res_data"},  32'(res_data),  32'd0);
  endtask

  // ------------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------------
  initial begin
    logic [PSUM_BW-1:0] got;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    start     = 1'b0;
    len       = '0;
    res_ready = 1'b0;
    #1;
    check_reset_outputs("por");
    tick();
    tick();
    reset = 1'b0;
    tick();

    // --- Reset in the middle of WAIT ---------------------------------------
    push_pair(4'd6, 4'd2);
    start_dot(1);             // now in ISSUE
    tick();                   // popped, now in WAIT
    check("rst_pre_mac_a", 32'(mac_a), 32'd6);
    check("rst_pre_busy",  32'(busy),  32'd1);
    reset = 1'b1;
    #1;
    model_q.delete();
    check_reset_outputs("rst_mid");
    tick();
    reset = 1'b0;
    tick();
    check_reset_outputs("rst_post");

    // --- Basic: (1,1),(15,-8),(2,3) -> -113 --------------------------------
    push_pair(4'd1,  4'd1);
    push_pair(4'd15, 4'h8);
    push_pair(4'd2,  4'd3);
    start_dot(3);
    wait_result("basic", 3, 3 * (MAC_LAT + 1) + 1, 1'b0, got);
    check("basic_const", 32'(got), 32'h0000_FF8F);
    check("basic_mac_a_hold", 32'(mac_a), 32'd2);
    check("basic_mac_b_hold", 32'(mac_b), 32'd3);

    // --- len = 0: immediate zero result, FIFO untouched --------------------
    push_pair(4'd3, 4'hE);    // (3,-2)
    push_pair(4'd7, 4'd5);
    start_dot(0);
    check("len0_valid_next", 32'(res_valid), 32'd1);
    check("len0_data",       32'(res_data),  32'd0);
    start = 1'b1;             // must be ignored while DONE
    len   = LEN_W'(3);
    repeat (10) tick();
    check("len0_hold_valid", 32'(res_valid), 32'd1);
    check("len0_hold_data",  32'(res_data),  32'd0);
    res_ready = 1'b1;         // start still high during the handshake
    tick();
    res_ready = 1'b0;
    start     = 1'b0;
    check("len0_hs_idle",  32'(busy),      32'd0);
    check("len0_hs_valid", 32'(res_valid), 32'd0);
    tick();
    check("len0_start_ignored", 32'(busy), 32'd0);
    start_dot(2);
    wait_result("len0_fifo", 2, 2 * (MAC_LAT + 1) + 1, 1'b0, got);
    check("len0_fifo_const", 32'(got), 32'd29);

    // --- Starvation: empty FIFO, pairs arrive late -------------------------
    start_dot(2);
    repeat (3) tick();
    check("starve_busy",  32'(busy),      32'd1);
    check("starve_valid", 32'(res_valid), 32'd0);
    check("starve_mac_a", 32'(mac_a),     32'd7);
    check("starve_mac_b", 32'(mac_b),     32'd5);
    check("starve_mac_c", 32'(mac_c),     32'd0);
    push_pair(4'd9, 4'hD);    // (9,-3)
    repeat (4) tick();
    check("starve2_mac_a", 32'(mac_a), 32'd9);
    check("starve2_mac_b", 32'(mac_b), 32'hD);
    check("starve2_mac_c", 32'(mac_c), 32'h0000_FFE5);
    check("starve2_busy",  32'(busy),  32'd1);
    push_pair(4'd4, 4'd6);
    wait_result("starve", 2, -1, 1'b0, got);
    check("starve_const", 32'(got), 32'h0000_FFFD);

    // --- Long run: 255 x (15,7) -------------------------------------------
    push_mode   = 2;
    push_budget = 255;
    repeat (4) tick();        // prefill
    start_dot(255);
    wait_result("long", 255, 255 * (MAC_LAT + 1) + 1, 1'b0, got);
    check("long_const", 32'(got), 32'h0000_6897);
    push_mode = 0;
    in_valid  = 1'b0;

    // --- Full FIFO and back-pressure --------------------------------------
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_a     = BW'(i + 2);
      in_b     = BW'(15 - i);
      tick();
      if (i == 3) check("full_after4", 32'(in_ready), 32'd0);
    end
    check("full_accepted", 32'(model_q.size()), 32'd4);
    in_a = 4'd11;             // (11,-1) held on the input
    in_b = 4'hF;
    start_dot(4);             // now ISSUE with a full FIFO
    check("full_issue_ready", 32'(in_ready), 32'd0);
    tick();                   // pop only; push refused
    check("full_pop_ready",   32'(in_ready), 32'd1);
    tick();                   // push lands
    check("full_refill_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    wait_result("full", 4, 4 * (MAC_LAT + 1) + 1, 1'b0, got);

    // --- Randomized rounds -------------------------------------------------
    push_mode = 1;
    for (int r = 0; r < 25; r++) begin
      int n = $urandom_range(1, 6);
      repeat ($urandom_range(0, 4)) tick();
      start_dot(n);
      wait_result($sformatf("rand%0d", r), n, -1, 1'b1, got);
    end
    push_mode = 0;
    in_valid  = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_mac_seq
